uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Receive-side byte FIFO between the UART and the 6502 CPU bus.
//             Bytes strobed in by the UART are queued in a circular buffer.
//             The CPU pops them through a DATA register and observes or
//             controls the FIFO through a STATUS/CTRL register. A level IRQ
//             is raised while data is pending or an overflow is latched.
//  Ports    : clk             - single clock, rising edge
//             rst_n           - asynchronous active-low reset
//             uart_byte       - received byte
//             uart_byte_ready - one-cycle strobe qualifying uart_byte
//             cs              - CPU bus select
//             addr            - 0 = DATA, 1 = STATUS/CTRL
//             we              - CPU write enable (read is cs & ~we)
//             wdata           - CPU write data
//             rdata           - registered read data (one-cycle latency)
//             irq             - registered level interrupt request
//  Register : STATUS read = {ovf, full, empty, count[4:0] (saturating at 31)}
//             CTRL write  : bit0 irq_en, bit1 flush, bit7 clear ovf
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] uart_byte,
    input  logic       uart_byte_ready,
    input  logic       cs,
    input  logic       addr,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Storage is deliberately left out of reset.
    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          irq_en;

    logic          bus_rd;
    logic          data_rd;
    logic          status_rd;
    logic          ctrl_wr;
    logic          flush;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic          ovf_clr;
    logic [4:0]    count_field;
    logic [7:0]    status_byte;
    logic          unused_wdata;

    assign bus_rd    = cs & ~we;
    assign data_rd   = bus_rd & ~addr;
    assign status_rd = bus_rd & addr;
    assign ctrl_wr   = cs & we & addr;
    assign flush     = ctrl_wr & wdata[1];
    assign ovf_clr   = ctrl_wr & wdata[7];

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Every read bus cycle on DATA is a pop attempt; it only takes effect
    // when something is queued.
    assign pop = data_rd & ~empty;

    // A same-cycle pop frees a slot, so a push into a full FIFO still
    // lands. Flush discards any coincident push without flagging overflow.
    assign push    = uart_byte_ready & (~full | pop) & ~flush;
    assign ovf_set = uart_byte_ready & full & ~pop & ~flush;

    generate
        if (CW > 5) begin : g_count_sat
            assign count_field = (count > CW'(31)) ? 5'd31 : count[4:0];
        end else begin : g_count_ext
            assign count_field = 5'(count);
        end
    endgenerate

    assign status_byte = {ovf, full, empty, count_field};

    // Bits 6..2 of a CTRL write carry no function.
    assign unused_wdata = ^wdata[6:2];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= uart_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            irq_en <= 1'b1;
            rdata  <= 8'h00;
            irq    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end

            // Set has priority over a same-cycle clear.
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            if (ctrl_wr) begin
                irq_en <= wdata[0];
            end

            // Built from the current (already-updated) state, so irq trails
            // any state change by one cycle.
            irq <= irq_en & (~empty | ovf);

            if (data_rd) begin
                rdata <= pop ? mem[rd_ptr] : 8'h00;
            end else if (status_rd) begin
                rdata <= status_byte;
            end
        end
    end

endmodule

`default_nettype wire
